// File: rtl/sync_fifo_flags_if.sv
// Bus bundle for sync_fifo_flags: write/read requests from the master, data and
// occupancy status from the FIFO (slave).
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] din;
    logic             we_n;
    logic             oe_n;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output din, we_n, oe_n,
        input  dout, valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  din, we_n, oe_n,
        output dout, valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, registered occupancy flags and
// sticky overflow/underflow indicators.
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sync_fifo_flags_if.slave   bus,
    output logic               dbg_active_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] FULL_L = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  dout_q;
    logic              valid_q;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_acc;
    logic              rd_acc;

    // Handshake: requests are active-low levels sampled on each rising edge.
    // A read is accepted whenever the FIFO is non-empty; a write is accepted when
    // not full, or when full but a read is accepted in the same cycle. A request
    // that is not accepted is dropped and latches the matching sticky error flag.
    // Reset takes priority over both requests.
    always_comb begin
        rd_acc = !rst_i && !bus.oe_n && !empty_q;
        wr_acc = !rst_i && !bus.we_n && (!full_q || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (!bus.we_n && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (!bus.oe_n && !rd_acc) begin
            unf_d = 1'b1;
        end

        // Flags derive from the next count so they register alongside it.
        full_d  = (count_d == FULL_L);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_L);
        ae_d    = (count_d <= AE_L);
    end

    // Occupancy controller: leaves IDLE on the first accepted write only.
    always_comb begin
        state_d      = state_q;
        dbg_active_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                dbg_active_o = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= rd_acc;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; the pointers alone define what is live.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        bus.dout         = dout_q;
        bus.valid        = valid_q;
        bus.full         = full_q;
        bus.empty        = empty_q;
        bus.almost_full  = af_q;
        bus.almost_empty = ae_q;
        bus.count        = count_q;
        bus.overflow     = ovf_q;
        bus.underflow    = unf_q;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_sync_fifo_flags;
    localparam int WIDTH = 8;
    localparam int DEPTH = 1024;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;
    logic dbg_active;

    sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .dbg_active_o (dbg_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;

    int n_checks = 0;
    int n_fail   = 0;

    // driver: apply one cycle of requests, advance the model, settle past the edge
    task automatic cycle(input logic we_n, input logic oe_n, input logic [WIDTH-1:0] d);
        bit rd_ok;
        bit wr_ok;
        bus.we_n = we_n;
        bus.oe_n = oe_n;
        bus.din  = d;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rd_ok = !oe_n && (exp_q.size() > 0);
            wr_ok = !we_n && ((exp_q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(d);
            m_valid = rd_ok;
            if (!we_n && !wr_ok) m_ovf = 1'b1;
            if (!oe_n && !rd_ok) m_unf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 1'b1, '0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h5A);
        rst = 1'b0;
        n_checks++;
        if ({bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
             bus.valid, bus.dout, bus.overflow, bus.underflow, dbg_active} !==
            {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%h ov=%b un=%b act=%b required cnt=0 e=1 f=0 ae=1 af=0 v=0 d=00 ov=0 un=0 act=0",
                     bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                     bus.valid, bus.dout, bus.overflow, bus.underflow, dbg_active);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            n_checks++;
            if (bus.count !== CW'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_count: i=%0d got %0d required %0d", i, bus.count, i + 1);
            end
            n_checks++;
            if (bus.almost_full !== ((i + 1) >= AF)) begin
                n_fail++;
                $display("FAIL fill_af: cnt=%0d got %b required %b", i + 1, bus.almost_full, (i + 1) >= AF);
            end
            n_checks++;
            if (bus.full !== ((i + 1) == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_full: cnt=%0d got %b required %b", i + 1, bus.full, (i + 1) == DEPTH);
            end
        end
        n_checks++;
        if (dbg_active !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_active: got %b required 1", dbg_active);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'hEE);
        n_checks++;
        if ({bus.count, bus.full, bus.overflow, bus.underflow} !== {CW'(DEPTH), 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow: got cnt=%0d f=%b ov=%b un=%b required cnt=%0d f=1 ov=1 un=0",
                     bus.count, bus.full, bus.overflow, bus.underflow, DEPTH);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, '0);
            n_checks++;
            if ({bus.valid, bus.dout} !== {1'b1, 8'(i)}) begin
                n_fail++;
                $display("FAIL drain_data: i=%0d got v=%b d=%h required v=1 d=%h", i, bus.valid, bus.dout, 8'(i));
            end
            n_checks++;
            if (bus.almost_empty !== ((DEPTH - 1 - i) <= AE)) begin
                n_fail++;
                $display("FAIL drain_ae: cnt=%0d got %b required %b", DEPTH - 1 - i, bus.almost_empty, (DEPTH - 1 - i) <= AE);
            end
        end
        n_checks++;
        if ({bus.count, bus.empty, bus.underflow} !== {CW'(0), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_end: got cnt=%0d e=%b un=%b required cnt=0 e=1 un=0", bus.count, bus.empty, bus.underflow);
        end
        cycle(1'b1, 1'b0, '0);
        n_checks++;
        if ({bus.underflow, bus.valid, bus.dout} !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL underflow_read: got un=%b v=%b d=%h required un=1 v=0 d=ff", bus.underflow, bus.valid, bus.dout);
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 8'($urandom));
            n_checks++;
            if ({bus.count, bus.full, bus.valid, bus.dout, bus.overflow} !==
                {CW'(DEPTH), 1'b1, 1'b1, m_dout, 1'b0}) begin
                n_fail++;
                $display("FAIL full_simul: i=%0d got cnt=%0d f=%b v=%b d=%h ov=%b required cnt=%0d f=1 v=1 d=%h ov=0",
                         i, bus.count, bus.full, bus.valid, bus.dout, bus.overflow, DEPTH, m_dout);
            end
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        cycle(1'b0, 1'b0, 8'hA5);
        n_checks++;
        if ({bus.count, bus.valid, bus.underflow, bus.empty} !== {CW'(1), 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_simul: got cnt=%0d v=%b un=%b e=%b required cnt=1 v=0 un=1 e=0",
                     bus.count, bus.valid, bus.underflow, bus.empty);
        end
        cycle(1'b1, 1'b0, '0);
        n_checks++;
        if ({bus.valid, bus.dout, bus.empty} !== {1'b1, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_simul_read: got v=%b d=%h e=%b required v=1 d=a5 e=1", bus.valid, bus.dout, bus.empty);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 500; i++) cycle(1'b0, 1'b1, 8'(i + 3));
        n_checks++;
        if ({bus.count, bus.underflow} !== {CW'(500), 1'b1}) begin
            n_fail++;
            $display("FAIL mid_pre: got cnt=%0d un=%b required cnt=500 un=1", bus.count, bus.underflow);
        end
        rst = 1'b1;
        cycle(1'b0, 1'b1, 8'h77);
        rst = 1'b0;
        n_checks++;
        if ({bus.count, bus.empty, bus.overflow, bus.underflow, dbg_active} !==
            {CW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d e=%b ov=%b un=%b act=%b required cnt=0 e=1 ov=0 un=0 act=0",
                     bus.count, bus.empty, bus.overflow, bus.underflow, dbg_active);
        end
        cycle(1'b1, 1'b0, '0);
        n_checks++;
        if ({bus.valid, bus.dout, bus.underflow} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_no_store: got v=%b d=%h un=%b required v=0 d=00 un=1", bus.valid, bus.dout, bus.underflow);
        end
    endtask

    task automatic test_random();
        logic [CW+WIDTH+6:0] act;
        logic [CW+WIDTH+6:0] exp;
        int sz;
        int wp;
        int rp;
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph % 2 == 0) ? 95 : 20;
            rp = (ph % 2 == 0) ? 20 : 95;
            for (int c = 0; c < 1500; c++) begin
                cycle(!($urandom_range(99, 0) < wp), !($urandom_range(99, 0) < rp), 8'($urandom));
                sz  = exp_q.size();
                act = {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                       bus.valid, bus.overflow, bus.underflow, bus.dout};
                exp = {CW'(sz), sz == DEPTH, sz == 0, sz >= AF, sz <= AE,
                       m_valid, m_ovf, m_unf, m_dout};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL random: ph=%0d c=%0d got %h required %h", ph, c, act, exp);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.we_n = 1'b1;
        bus.oe_n = 1'b1;
        bus.din  = '0;
        m_dout   = '0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_full_simul();
        test_empty_simul();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
